// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the DE1-SoC input conditioner: per-bit debounce FSM
// state encoding and default timing constants derived from the 50 MHz clock.
package input_conditioner_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } db_state_e;

  localparam int unsigned CLK_HZ              = 50_000_000;
  // 1 ms of stability before a change is believed
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 1000;
  // 0.5 s hold before the first auto-repeat, then 10 repeats per second
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, stability-counter debounce
// FSM, registered level and one-cycle rise/fall pulses.
// Optional auto-repeat of the rise pulse is compiled in with
// INPUT_CONDITIONER_AUTOREPEAT_EN and enabled per instance via REPEAT_EN.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        RESET_VAL       = 1'b0,
  parameter logic        INVERT          = 1'b0
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter logic        REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // One bit wider than the counter so the compare can never wrap
  localparam logic [CNT_W:0] DB_LIM  = (CNT_W + 1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

  logic             sync1_q, sync2_q;
  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             accept;
  logic             rep_hit;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Two-flop synchroniser; reset value matches the input's idle level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Polarity fix-up after synchronisation so the FSM always sees active-high
  assign s = sync2_q ^ INVERT;

  // FSM state and stability counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count consecutive disagreeing samples, any agreement restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cnt_inc = (state_q == ST_COUNT) ? ({1'b0, cnt_q} + CNT_ONE) : CNT_ONE;
    if (s == level_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (cnt_inc >= DB_LIM) begin
      accept  = 1'b1;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = ST_COUNT;
      cnt_d   = cnt_inc[CNT_W-1:0];
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_repeat
    logic [31:0] hold_q, hold_d;
    logic [31:0] target;
    logic        first_q, first_d;
    logic        hit;

    // Hold timer: first interval is the delay, later intervals the period
    always_comb begin
      hold_d  = hold_q + 32'd1;
      first_d = first_q;
      hit     = 1'b0;
      target  = first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD);
      // accept while level is high means a release is being taken
      if (!level_q || accept) begin
        hold_d  = '0;
        first_d = 1'b1;
      end else if (hold_d == target) begin
        hit     = 1'b1;
        hold_d  = '0;
        first_d = 1'b0;
      end
    end

    // Hold timer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q  <= '0;
        first_q <= 1'b1;
      end else begin
        hold_q  <= hold_d;
        first_q <= first_d;
      end
    end

    assign rep_hit = hit;
  end else begin : g_no_repeat
    assign rep_hit = 1'b0;
  end
`else
  assign rep_hit = 1'b0;
`endif

  // Output decode: level follows accepted samples, pulses mark the changes
  always_comb begin
    level_d = accept ? s : level_q;
    rise_d  = (accept & s) | rep_hit;
    fall_d  = accept & ~s;
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// DE1-SoC KEY/SW conditioner: one debounce_bit per input, KEY inverted to
// active-high pressed state. Define INPUT_CONDITIONER_AUTOREPEAT_EN to add
// held-key auto-repeat on key_press.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned N_KEY           = 4,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [N_KEY-1:0] KEY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change
);

  // Reject configurations the counter cannot represent
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("input_conditioner: illegal timing configuration");
  end

  logic [N_SW-1:0] sw_rise, sw_fall;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1),
      .INVERT         (1'b1)
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_EN      (1'b1),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_db (
      .clk_i  (CLOCK_50),
      .rst_ni (resetn),
      .raw_i  (KEY[i]),
      .level_o(key_level[i]),
      .rise_o (key_press[i]),
      .fall_o (key_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0),
      .INVERT         (1'b0)
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_EN      (1'b0),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_db (
      .clk_i  (CLOCK_50),
      .rst_ni (resetn),
      .raw_i  (SW[i]),
      .level_o(sw_level[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

  // Any accepted switch transition; both halves are already registered
  assign sw_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with short timing (debounce 4, repeat 20/8).
module tb_input_conditioner;

  localparam int NK = 4;
  localparam int NS = 10;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NK-1:0] KEY;
  logic [NS-1:0] SW;
  logic [NK-1:0] key_level, key_press, key_release;
  logic [NS-1:0] sw_level, sw_change;

  input_conditioner #(
    .N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(D), .CNT_W(16),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .KEY(KEY), .SW(SW),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .sw_level(sw_level), .sw_change(sw_change)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] kl, kp, kr;
    logic [NS-1:0] sl, sc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int kp_cnt[NK], kr_cnt[NK], last_kp[NK], last_kr[NK];
  int sc_cnt[NS], last_sc[NS];
  bit kl_seen[NK];
  int kp3_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a change is accepted when the D samples taken 2..D+1
  // edges ago all disagree with the current level (2 edges of synchroniser).
  bit hist[NK+NS][$];
  bit lvl[NK+NS];
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  int press_edge[NK];
`endif

  initial forever begin
    exp_t e;
    bit   v, all;
    @(posedge clk);
    cyc++;
    e = '0;
    if (!resetn) begin
      for (int b = 0; b < NK + NS; b++) begin
        hist[b].delete();
        for (int i = 0; i < D + 2; i++) hist[b].push_back(1'b0);
        lvl[b] = 1'b0;
      end
    end else begin
      for (int b = 0; b < NK + NS; b++) begin
        v = (b < NK) ? ~KEY[b] : SW[b-NK];
        hist[b].push_back(v);
        if (hist[b].size() > D + 2) void'(hist[b].pop_front());
        all = 1'b1;
        for (int i = 0; i < D; i++) if (hist[b][i] == lvl[b]) all = 1'b0;
        if (all) lvl[b] = ~lvl[b];
        if (b < NK) begin
          e.kl[b] = lvl[b];
          if (all && lvl[b]) begin
            e.kp[b] = 1'b1;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
            press_edge[b] = cyc;
`endif
          end
          if (all && !lvl[b]) e.kr[b] = 1'b1;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
          if (!all && lvl[b]) begin
            int age;
            age = cyc - press_edge[b];
            if (age >= RD && ((age - RD) % RP) == 0) e.kp[b] = 1'b1;
          end
`endif
        end else begin
          e.sl[b-NK] = lvl[b];
          e.sc[b-NK] = all;
        end
      end
    end
    sb_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents outputs; compare against the queue
  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (cyc > 0) begin
      a = {key_level, key_press, key_release, sw_level, sw_change};
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        if (!resetn) e = '0;
        chk("outputs", 64'(a), 64'(e));
      end
      for (int b = 0; b < NK; b++) begin
        if (key_press[b])   begin kp_cnt[b]++; last_kp[b] = cyc; if (b == 3) kp3_cyc.push_back(cyc); end
        if (key_release[b]) begin kr_cnt[b]++; last_kr[b] = cyc; end
        if (key_level[b])   kl_seen[b] = 1'b1;
      end
      for (int b = 0; b < NS; b++)
        if (sw_change[b]) begin sc_cnt[b]++; last_sc[b] = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int e0, a0, s0, s1;
    int exp_rep[$];
    resetn = 1'b0;
    KEY    = '0;
    SW     = '1;
    tick(3);
    chk("reset_outputs", 64'({key_level, key_press, key_release, sw_level, sw_change}), 64'd0);

    // Inputs held active across reset release
    resetn = 1'b1;
    e0 = cyc;
    tick(10);
    chk("rst_key_level", 64'(key_level), 64'hF);
    chk("rst_sw_level", 64'(sw_level), 64'h3FF);
    for (int b = 0; b < NK; b++) begin
      chk($sformatf("rst_kp_cnt%0d", b), 64'(kp_cnt[b]), 64'd1);
      chk($sformatf("rst_kp_cyc%0d", b), 64'(last_kp[b]), 64'(e0 + 6));
    end
    for (int b = 0; b < NS; b++) begin
      chk($sformatf("rst_sc_cnt%0d", b), 64'(sc_cnt[b]), 64'd1);
      chk($sformatf("rst_sc_cyc%0d", b), 64'(last_sc[b]), 64'(e0 + 6));
    end
    KEY = '1;
    SW  = '0;
    tick(12);

    // Clean press on KEY[1]
    s0 = kp_cnt[0] + kp_cnt[2] + kp_cnt[3];
    s1 = kp_cnt[1];
    KEY[1] = 1'b0;
    e0 = cyc;
    tick(8);
    chk("press1_cyc", 64'(last_kp[1]), 64'(e0 + 6));
    chk("press1_cnt", 64'(kp_cnt[1] - s1), 64'd1);
    chk("press1_level", 64'(key_level), 64'h2);
    chk("press1_others", 64'(kp_cnt[0] + kp_cnt[2] + kp_cnt[3] - s0), 64'd0);
    s1 = kr_cnt[1];
    KEY[1] = 1'b1;
    e0 = cyc;
    tick(8);
    chk("release1_cnt", 64'(kr_cnt[1] - s1), 64'd1);
    chk("release1_cyc", 64'(last_kr[1]), 64'(e0 + 6));

    // Bouncing switch settles high
    s0 = sc_cnt[3];
    SW[3] = 1'b1; tick(2);
    SW[3] = 1'b0; tick(2);
    SW[3] = 1'b1;
    e0 = cyc;
    tick(10);
    chk("bounce_cnt", 64'(sc_cnt[3] - s0), 64'd1);
    chk("bounce_cyc", 64'(last_sc[3]), 64'(e0 + 6));
    chk("bounce_level", 64'(sw_level), 64'h008);

    // Glitch shorter than the debounce window
    s0 = kp_cnt[0];
    s1 = kr_cnt[0];
    kl_seen[0] = 1'b0;
    KEY[0] = 1'b0; tick(3);
    KEY[0] = 1'b1; tick(10);
    chk("glitch_press", 64'(kp_cnt[0] - s0), 64'd0);
    chk("glitch_release", 64'(kr_cnt[0] - s1), 64'd0);
    chk("glitch_level", 64'(kl_seen[0]), 64'd0);

    // Reset in the middle of a count, key held throughout
    KEY[2] = 1'b0;
    tick(3);
    resetn = 1'b0;
    tick(2);
    chk("midrst_outputs", 64'({key_level, key_press, key_release, sw_level, sw_change}), 64'd0);
    s0 = kp_cnt[2];
    resetn = 1'b1;
    e0 = cyc;
    tick(10);
    chk("midrst_cnt", 64'(kp_cnt[2] - s0), 64'd1);
    chk("midrst_cyc", 64'(last_kp[2]), 64'(e0 + 6));
    KEY[2] = 1'b1;
    tick(10);

    // Long hold on KEY[3]: level high for 60 cycles after acceptance
    kp3_cyc.delete();
    s1 = kr_cnt[3];
    KEY[3] = 1'b0;
    tick(6);
    a0 = cyc;
    tick(54);
    KEY[3] = 1'b1;
    tick(10);
    exp_rep.push_back(a0);
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    for (int t = RD; t < 60; t += RP) exp_rep.push_back(a0 + t);
`endif
    chk("repeat_count", 64'(kp3_cyc.size()), 64'(exp_rep.size()));
    foreach (exp_rep[i])
      if (i < kp3_cyc.size())
        chk($sformatf("repeat_cyc%0d", i), 64'(kp3_cyc[i]), 64'(exp_rep[i]));
    chk("repeat_release_cnt", 64'(kr_cnt[3] - s1), 64'd1);
    chk("repeat_release_cyc", 64'(last_kr[3]), 64'(a0 + 60));

    // Random traffic, including occasional resets and long key holds
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        resetn = 1'b0;
        tick($urandom_range(1, 3));
        resetn = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, NK + NS - 1);
        if (b < NK) KEY[b] = ~KEY[b];
        else        SW[b-NK] = ~SW[b-NK];
      end
      tick(1);
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
